// File: rtl/gen_defines.sv
// rtl/gen_defines.sv - shared FSM encodings and instruction-length constants for the branch slave
package gen_defines;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } br_state_e;

    localparam int unsigned LEN_RV32 = 4;
    localparam int unsigned LEN_RV16 = 2;

endpackage

// File: rtl/ex_branch_tgt.sv
// rtl/ex_branch_tgt.sv - combinational flush-target mux and adder
import gen_defines::*;

module ex_branch_tgt #(
    parameter int PC_SIZE = 32
) (
    input  logic               mret_i,
    input  logic               dret_i,
    input  logic               fencei_i,
    input  logic               rslv_i,
    input  logic               rv32_i,
    input  logic [PC_SIZE-1:0] pc_i,
    input  logic [PC_SIZE-1:0] imm_i,
    input  logic [PC_SIZE-1:0] epc_i,
    input  logic [PC_SIZE-1:0] dpc_i,
    output logic [PC_SIZE-1:0] tgt_o
);

    logic [PC_SIZE-1:0] len;
    logic [PC_SIZE-1:0] seq_pc;
    logic [PC_SIZE-1:0] jmp_pc;

    assign len    = rv32_i ? PC_SIZE'(LEN_RV32) : PC_SIZE'(LEN_RV16);
    assign seq_pc = pc_i + len;
    assign jmp_pc = pc_i + imm_i;

    // Return instructions outrank fence.i, which outranks the branch outcome.
    always_comb begin
        tgt_o = seq_pc;
        if (mret_i) begin
            tgt_o = epc_i;
        end else if (dret_i) begin
            tgt_o = dpc_i;
        end else if (fencei_i) begin
            tgt_o = seq_pc;
        end else if (rslv_i) begin
            tgt_o = jmp_pc;
        end
    end

endmodule

// File: rtl/ex_branch_slv.sv
// rtl/ex_branch_slv.sv - commit-stage branch slave: flush request FSM and prediction statistics
import gen_defines::*;

module ex_branch_slv #(
    parameter int PC_SIZE = 32,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmt_i_valid,
    output logic               cmt_i_ready,
    input  logic               cmt_i_bjp,
    input  logic               cmt_i_mret,
    input  logic               cmt_i_dret,
    input  logic               cmt_i_fencei,
    input  logic               cmt_i_prdt,
    input  logic               cmt_i_rslv,
    input  logic [PC_SIZE-1:0] cmt_i_pc,
    input  logic [PC_SIZE-1:0] cmt_i_imm,
    input  logic               cmt_i_rv32,
    input  logic [PC_SIZE-1:0] csr_epc_r,
    input  logic [PC_SIZE-1:0] csr_dpc_r,
    output logic               flush_o_valid,
    input  logic               flush_o_ready,
    output logic [PC_SIZE-1:0] flush_o_pc,
    output logic               flush_pend,
    output logic [CNT_W-1:0]   bjp_cnt,
    output logic [CNT_W-1:0]   mispred_cnt
);

    br_state_e          state_q, state_d;
    logic [PC_SIZE-1:0] flush_pc_q, flush_pc_d;
    logic [CNT_W-1:0]   bjp_cnt_q, bjp_cnt_d;
    logic [CNT_W-1:0]   mispred_cnt_q, mispred_cnt_d;
    logic [PC_SIZE-1:0] tgt;
    logic               accept;
    logic               mispred;
    logic               need_flush;

    ex_branch_tgt #(.PC_SIZE(PC_SIZE)) u_tgt (
        .mret_i   (cmt_i_mret),
        .dret_i   (cmt_i_dret),
        .fencei_i (cmt_i_fencei),
        .rslv_i   (cmt_i_rslv),
        .rv32_i   (cmt_i_rv32),
        .pc_i     (cmt_i_pc),
        .imm_i    (cmt_i_imm),
        .epc_i    (csr_epc_r),
        .dpc_i    (csr_dpc_r),
        .tgt_o    (tgt)
    );

    assign mispred    = cmt_i_bjp & (cmt_i_prdt != cmt_i_rslv);
    assign need_flush = cmt_i_mret | cmt_i_dret | cmt_i_fencei | mispred;
    assign accept     = cmt_i_valid & cmt_i_ready;

    // Outputs come straight from state so the IFU never sees a combinational path from cmt_i_*.
    always_comb begin
        state_d       = state_q;
        flush_pc_d    = flush_pc_q;
        bjp_cnt_d     = bjp_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        cmt_i_ready   = 1'b0;
        flush_o_valid = 1'b0;
        flush_pend    = 1'b0;
        case (state_q)
            IDLE: begin
                cmt_i_ready = 1'b1;
                if (accept) begin
                    if (cmt_i_bjp) begin
                        bjp_cnt_d = bjp_cnt_q + CNT_W'(1);
                    end
                    if (mispred) begin
                        mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
                    end
                    if (need_flush) begin
                        flush_pc_d = tgt;
                        state_d    = FLUSH;
                    end
                end
            end
            FLUSH: begin
                flush_o_valid = 1'b1;
                flush_pend    = 1'b1;
                if (flush_o_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            flush_pc_q    <= '0;
            bjp_cnt_q     <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            flush_pc_q    <= flush_pc_d;
            bjp_cnt_q     <= bjp_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign flush_o_pc  = flush_pc_q;
    assign bjp_cnt     = bjp_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_ex_branch_slv.sv
// tb/tb_ex_branch_slv.sv - directed and randomized checks of ex_branch_slv against a behavioural model
module tb_ex_branch_slv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmt_i_valid = 1'b0;
    logic        cmt_i_ready;
    logic        cmt_i_bjp = 1'b0, cmt_i_mret = 1'b0, cmt_i_dret = 1'b0, cmt_i_fencei = 1'b0;
    logic        cmt_i_prdt = 1'b0, cmt_i_rslv = 1'b0, cmt_i_rv32 = 1'b1;
    logic [31:0] cmt_i_pc = '0, cmt_i_imm = '0, csr_epc_r = '0, csr_dpc_r = '0;
    logic        flush_o_valid;
    logic        flush_o_ready = 1'b0;
    logic [31:0] flush_o_pc;
    logic        flush_pend;
    logic [31:0] bjp_cnt, mispred_cnt;

    int total = 0;
    int bad   = 0;

    // Reference state: is a flush outstanding, to where, and the two tallies.
    bit          m_flush = 0;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_bjp   = '0;
    logic [31:0] m_mis   = '0;

    ex_branch_slv dut (
        .clk(clk), .rst(rst),
        .cmt_i_valid(cmt_i_valid), .cmt_i_ready(cmt_i_ready),
        .cmt_i_bjp(cmt_i_bjp), .cmt_i_mret(cmt_i_mret), .cmt_i_dret(cmt_i_dret),
        .cmt_i_fencei(cmt_i_fencei), .cmt_i_prdt(cmt_i_prdt), .cmt_i_rslv(cmt_i_rslv),
        .cmt_i_pc(cmt_i_pc), .cmt_i_imm(cmt_i_imm), .cmt_i_rv32(cmt_i_rv32),
        .csr_epc_r(csr_epc_r), .csr_dpc_r(csr_dpc_r),
        .flush_o_valid(flush_o_valid), .flush_o_ready(flush_o_ready),
        .flush_o_pc(flush_o_pc), .flush_pend(flush_pend),
        .bjp_cnt(bjp_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_target();
        logic [31:0] len;
        len = cmt_i_rv32 ? 32'd4 : 32'd2;
        if (cmt_i_mret)        return csr_epc_r;
        else if (cmt_i_dret)   return csr_dpc_r;
        else if (cmt_i_fencei) return cmt_i_pc + len;
        else if (cmt_i_rslv)   return cmt_i_pc + cmt_i_imm;
        else                   return cmt_i_pc + len;
    endfunction

    task automatic clear_inputs();
        cmt_i_valid = 0; cmt_i_bjp = 0; cmt_i_mret = 0; cmt_i_dret = 0; cmt_i_fencei = 0;
        cmt_i_prdt = 0; cmt_i_rslv = 0; cmt_i_rv32 = 1; cmt_i_pc = '0; cmt_i_imm = '0;
        flush_o_ready = 0;
    endtask

    // Called at a falling edge with inputs already set: compare, advance the model, clock once.
    task automatic cycle();
        bit mis, nf;
        check("ready", cmt_i_ready, !m_flush);
        check("valid", flush_o_valid, m_flush);
        check("pend", flush_pend, m_flush);
        if (m_flush) check("flush_pc", flush_o_pc, m_pc);
        check("bjp_cnt", bjp_cnt, m_bjp);
        check("mis_cnt", mispred_cnt, m_mis);
        if (m_flush) begin
            if (flush_o_ready) m_flush = 0;
        end else if (cmt_i_valid) begin
            mis = cmt_i_bjp && (cmt_i_prdt != cmt_i_rslv);
            nf  = cmt_i_mret || cmt_i_dret || cmt_i_fencei || mis;
            if (cmt_i_bjp) m_bjp++;
            if (mis) m_mis++;
            if (nf) begin
                m_flush = 1;
                m_pc    = ref_target();
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        @(negedge clk);
        check("rst_valid", flush_o_valid, 0);
        check("rst_pend", flush_pend, 0);
        check("rst_pc", flush_o_pc, 0);
        check("rst_bjp", bjp_cnt, 0);
        check("rst_mis", mispred_cnt, 0);
        rst = 0;
        @(negedge clk);
        check("rst_ready", cmt_i_ready, 1);

        // Correctly predicted taken branch: no flush.
        cmt_i_valid = 1; cmt_i_bjp = 1; cmt_i_prdt = 1; cmt_i_rslv = 1; cmt_i_pc = 32'h100;
        cycle();
        clear_inputs();
        check("c1_ready", cmt_i_ready, 1);
        check("c1_valid", flush_o_valid, 0);
        check("c1_bjp", bjp_cnt, 1);
        check("c1_mis", mispred_cnt, 0);
        cycle();

        // Mispredicted taken branch.
        cmt_i_valid = 1; cmt_i_bjp = 1; cmt_i_prdt = 0; cmt_i_rslv = 1;
        cmt_i_pc = 32'h100; cmt_i_imm = 32'h40;
        cycle();
        clear_inputs();
        check("c2_valid", flush_o_valid, 1);
        check("c2_pc", flush_o_pc, 32'h140);
        check("c2_mis", mispred_cnt, 1);
        flush_o_ready = 1;
        cycle();
        flush_o_ready = 0;
        check("c2_ready_after", cmt_i_ready, 1);

        // Mispredicted not-taken compressed branch with IFU back-pressure.
        cmt_i_valid = 1; cmt_i_bjp = 1; cmt_i_prdt = 1; cmt_i_rslv = 0;
        cmt_i_rv32 = 0; cmt_i_pc = 32'h200;
        cycle();
        clear_inputs();
        cmt_i_valid = 1;
        for (int i = 0; i < 4; i++) begin
            check("c3_pc", flush_o_pc, 32'h202);
            check("c3_ready", cmt_i_ready, 0);
            check("c3_valid", flush_o_valid, 1);
            flush_o_ready = (i == 3);
            cycle();
        end
        clear_inputs();

        // mret wins over fencei; returns do not count.
        cmt_i_valid = 1; cmt_i_mret = 1; cmt_i_fencei = 1; csr_epc_r = 32'h8000_0000;
        cycle();
        clear_inputs();
        check("c4_pc", flush_o_pc, 32'h8000_0000);
        check("c4_bjp", bjp_cnt, 3);
        check("c4_mis", mispred_cnt, 2);
        flush_o_ready = 1;
        cycle();
        clear_inputs();

        // Address wrap.
        cmt_i_valid = 1; cmt_i_bjp = 1; cmt_i_prdt = 0; cmt_i_rslv = 1;
        cmt_i_pc = 32'hFFFF_FFFC; cmt_i_imm = 32'h8;
        cycle();
        clear_inputs();
        check("c5_pc", flush_o_pc, 32'h4);
        check("c5_valid", flush_o_valid, 1);

        // Asynchronous reset while the flush is outstanding.
        rst = 1;
        #1;
        check("c6_valid_async", flush_o_valid, 0);
        check("c6_pend_async", flush_pend, 0);
        @(negedge clk);
        rst = 0;
        m_flush = 0; m_pc = '0; m_bjp = '0; m_mis = '0;
        @(negedge clk);
        check("c6_ready", cmt_i_ready, 1);
        check("c6_bjp", bjp_cnt, 0);
        check("c6_mis", mispred_cnt, 0);
        check("c6_valid", flush_o_valid, 0);

        for (int n = 0; n < 3000; n++) begin
            cmt_i_valid   = ($urandom_range(0, 3) != 0);
            cmt_i_bjp     = ($urandom_range(0, 1) == 1);
            cmt_i_mret    = ($urandom_range(0, 7) == 0);
            cmt_i_dret    = ($urandom_range(0, 7) == 0);
            cmt_i_fencei  = ($urandom_range(0, 7) == 0);
            cmt_i_prdt    = $urandom_range(0, 1) == 1;
            cmt_i_rslv    = $urandom_range(0, 1) == 1;
            cmt_i_rv32    = $urandom_range(0, 1) == 1;
            cmt_i_pc      = $urandom;
            cmt_i_imm     = $urandom;
            csr_epc_r     = $urandom;
            csr_dpc_r     = $urandom;
            flush_o_ready = ($urandom_range(0, 1) == 1);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
